ddr_judge: RTL and testbench

DDR_JUDGE -- requirements
Module: ddr_judge

---
 rtl/ddr_judge_if.sv | 21 ++
 rtl/ddr_judge.sv | 216 +++++++++++++++++++++
 tb/tb_ddr_judge.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_judge_if.sv
// Note-issue handshake between the chart sequencer (master) and the judge (slave).
// A note is offered with a lane mask and accepted only when every lane is idle.
interface ddr_judge_if #(
    parameter int LANES = 4
);
    logic             note_valid_i;
    logic             note_ready_o;
    logic [LANES-1:0] note_mask_i;

    modport master (
        output note_valid_i,
        output note_mask_i,
        input  note_ready_o
    );

    modport slave (
        input  note_valid_i,
        input  note_mask_i,
        output note_ready_o
    );
endinterface

// File: rtl/ddr_judge.sv
// Rhythm-game timing judge: per-lane note FSMs grade presses against a frame countdown
// and keep saturating score, combo and best-combo totals.
module ddr_judge #(
    parameter int LANES       = 4,
    parameter int TRAVEL      = 60,
    parameter int PERFECT_WIN = 2,
    parameter int GOOD_WIN    = 5,
    parameter int PTS_PERFECT = 3,
    parameter int PTS_GOOD    = 1,
    parameter int SCOREW      = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                frame_i,
    input  logic [LANES-1:0]    press_i,
    ddr_judge_if.slave          note_if,
    output logic [LANES-1:0]    lane_active_o,
    output logic [LANES-1:0]    judge_valid_o,
    output logic [2*LANES-1:0]  judge_code_o,
    output logic [SCOREW-1:0]   score_o,
    output logic [SCOREW-1:0]   combo_o,
    output logic [SCOREW-1:0]   max_combo_o
);

    localparam int CW = $clog2(TRAVEL + 1);
    localparam int NW = $clog2(LANES + 1);
    localparam int AW = SCOREW + 16;

    localparam logic [CW-1:0]     C_TRAVEL = CW'(TRAVEL);
    localparam logic [CW-1:0]     C_PWIN   = CW'(PERFECT_WIN);
    localparam logic [CW-1:0]     C_GWIN   = CW'(GOOD_WIN);
    localparam logic [AW-1:0]     A_MAX    = {{(AW-SCOREW){1'b0}}, {SCOREW{1'b1}}};
    localparam logic [SCOREW-1:0] S_MAX    = {SCOREW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_APPROACH = 2'd1,
        S_LATE     = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        J_MISS    = 2'd0,
        J_GOOD    = 2'd1,
        J_PERFECT = 2'd2,
        J_STRAY   = 2'd3
    } code_t;

    state_t               r_state [LANES];
    logic [CW-1:0]        r_cnt   [LANES];
    logic [LANES-1:0]     r_jv;
    logic [2*LANES-1:0]   r_jc;
    logic [SCOREW-1:0]    r_score;
    logic [SCOREW-1:0]    r_combo;
    logic [SCOREW-1:0]    r_max;

    state_t               w_state_nxt [LANES];
    logic [CW-1:0]        w_cnt_nxt   [LANES];
    logic [LANES-1:0]     w_jv;
    logic [2*LANES-1:0]   w_jc;
    logic [NW-1:0]        w_np;
    logic [NW-1:0]        w_ng;
    logic                 w_bad;
    logic                 w_ready;
    logic                 w_issue;
    logic [AW-1:0]        w_score_sum;
    logic [AW-1:0]        w_combo_sum;
    logic [SCOREW-1:0]    w_score_nxt;
    logic [SCOREW-1:0]    w_combo_nxt;
    logic [SCOREW-1:0]    w_max_nxt;

    always_comb begin
        w_ready       = 1'b1;
        lane_active_o = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_active_o[l] = (r_state[l] != S_IDLE);
            if (r_state[l] != S_IDLE) w_ready = 1'b0;
        end
    end

    assign note_if.note_ready_o = w_ready;
    assign w_issue              = note_if.note_valid_i & w_ready;

    // Press is graded on the pre-update count, so it beats a same-cycle frame timeout.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_jv  = '0;
        w_jc  = '0;
        w_np  = '0;
        w_ng  = '0;
        w_bad = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            w_state_nxt[l] = r_state[l];
            w_cnt_nxt[l]   = r_cnt[l];
            unique case (r_state[l])
                S_IDLE: begin
                    if (press_i[l]) begin
                        w_jv[l]       = 1'b1;
                        w_jc[2*l +: 2] = J_STRAY;
                    end
                    if (w_issue && note_if.note_mask_i[l]) begin
                        w_state_nxt[l] = S_APPROACH;
                        w_cnt_nxt[l]   = C_TRAVEL;
                    end
                end
                S_APPROACH: begin
                    if (press_i[l] && r_cnt[l] <= C_GWIN) begin
                        w_jv[l]        = 1'b1;
                        w_jc[2*l +: 2] = (r_cnt[l] <= C_PWIN) ? J_PERFECT : J_GOOD;
                        w_state_nxt[l] = S_IDLE;
                        w_cnt_nxt[l]   = '0;
                    end else begin
                        if (press_i[l]) begin
                            w_jv[l]        = 1'b1;
                            w_jc[2*l +: 2] = J_STRAY;
                        end
                        if (frame_i) begin
                            if (r_cnt[l] == '0) begin
                                w_state_nxt[l] = S_LATE;
                                w_cnt_nxt[l]   = CW'(1);
                            end else begin
                                w_cnt_nxt[l]   = r_cnt[l] - CW'(1);
                            end
                        end
                    end
                end
                S_LATE: begin
                    if (press_i[l]) begin
                        w_jv[l]        = 1'b1;
                        w_jc[2*l +: 2] = (r_cnt[l] <= C_PWIN) ? J_PERFECT : J_GOOD;
                        w_state_nxt[l] = S_IDLE;
                        w_cnt_nxt[l]   = '0;
                    end else if (frame_i) begin
                        if (r_cnt[l] >= C_GWIN) begin
                            w_jv[l]        = 1'b1;
                            w_jc[2*l +: 2] = J_MISS;
                            w_state_nxt[l] = S_IDLE;
                            w_cnt_nxt[l]   = '0;
                        end else begin
                            w_cnt_nxt[l]   = r_cnt[l] + CW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt[l] = S_IDLE;
                    w_cnt_nxt[l]   = '0;
                end
            endcase

            if (w_jv[l]) begin
                unique case (w_jc[2*l +: 2])
                    J_PERFECT: w_np  = w_np + NW'(1);
                    J_GOOD:    w_ng  = w_ng + NW'(1);
                    default:   w_bad = 1'b1;
                endcase
            end
        end
    end

    // Totals are summed in a wider accumulator and clamped back to SCOREW bits.
    always_comb begin
        w_score_sum = AW'(r_score) + AW'(PTS_PERFECT) * AW'(w_np) + AW'(PTS_GOOD) * AW'(w_ng);
        w_combo_sum = AW'(r_combo) + AW'(w_np) + AW'(w_ng);
        w_score_nxt = (w_score_sum > A_MAX) ? S_MAX : w_score_sum[SCOREW-1:0];
        if (w_bad) begin
            w_combo_nxt = '0;
        end else begin
            w_combo_nxt = (w_combo_sum > A_MAX) ? S_MAX : w_combo_sum[SCOREW-1:0];
        end
        w_max_nxt = (w_combo_nxt > r_max) ? w_combo_nxt : r_max;
    end

    // NOTE: the per-lane state arrays are reset like any other register; an unreset
    // lane would start in an unknown state and could block the handshake forever.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l < LANES; l++) begin
                r_state[l] <= S_IDLE;
                r_cnt[l]   <= '0;
            end
            r_jv    <= '0;
            r_jc    <= '0;
            r_score <= '0;
            r_combo <= '0;
            r_max   <= '0;
        end else if (clear_i) begin
            for (int l = 0; l < LANES; l++) begin
                r_state[l] <= S_IDLE;
                r_cnt[l]   <= '0;
            end
            r_jv    <= '0;
            r_jc    <= '0;
            r_score <= '0;
            r_combo <= '0;
            r_max   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            for (int l = 0; l < LANES; l++) begin
                r_state[l] <= w_state_nxt[l];
                r_cnt[l]   <= w_cnt_nxt[l];
            end
            r_jv    <= w_jv;
            r_jc    <= w_jc;
            r_score <= w_score_nxt;
            r_combo <= w_combo_nxt;
            r_max   <= w_max_nxt;
        end
    end

    assign judge_valid_o = r_jv;
    assign judge_code_o  = r_jc;
    assign score_o       = r_score;
    assign combo_o       = r_combo;
    assign max_combo_o   = r_max;

endmodule

// File: tb/tb_ddr_judge.sv
// Directed bench for ddr_judge: default instance for judging/combo/clear, and a
// SCOREW=4 instance for score saturation and mid-flight asynchronous reset.
module tb_ddr_judge;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        rst2_ni;
    logic        clear;
    logic        clear2;
    logic        frame;
    logic [3:0]  press;
    logic [3:0]  press2;

    logic [3:0]  active,  jv;
    logic [7:0]  jc;
    logic [15:0] score, combo, max_combo;

    logic [3:0]  active2, jv2;
    logic [7:0]  jc2;
    logic [3:0]  score2, combo2, max_combo2;

    int total = 0;
    int bad   = 0;

    ddr_judge_if #(.LANES(4)) nif ();
    ddr_judge_if #(.LANES(4)) nif2 ();

    ddr_judge dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .clear_i       (clear),
        .frame_i       (frame),
        .press_i       (press),
        .note_if       (nif),
        .lane_active_o (active),
        .judge_valid_o (jv),
        .judge_code_o  (jc),
        .score_o       (score),
        .combo_o       (combo),
        .max_combo_o   (max_combo)
    );

    ddr_judge #(.SCOREW(4)) dut2 (
        .clk_i         (clk),
        .rst_ni        (rst2_ni),
        .clear_i       (clear2),
        .frame_i       (frame),
        .press_i       (press2),
        .note_if       (nif2),
        .lane_active_o (active2),
        .judge_valid_o (jv2),
        .judge_code_o  (jc2),
        .score_o       (score2),
        .combo_o       (combo2),
        .max_combo_o   (max_combo2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge, pulses drop.
    task automatic cyc();
        @(posedge clk);
        #1;
        frame             = 1'b0;
        press             = '0;
        press2            = '0;
        clear             = 1'b0;
        clear2            = 1'b0;
        nif.note_valid_i  = 1'b0;
        nif2.note_valid_i = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame = 1'b1;
            cyc();
            cyc();
        end
    endtask

    task automatic issue(input logic [3:0] mask);
        nif.note_valid_i = 1'b1;
        nif.note_mask_i  = mask;
        cyc();
    endtask

    task automatic issue2(input logic [3:0] mask);
        nif2.note_valid_i = 1'b1;
        nif2.note_mask_i  = mask;
        cyc();
    endtask

    initial begin
        rst_ni = 1'b0; rst2_ni = 1'b0;
        clear = 1'b0; clear2 = 1'b0; frame = 1'b0;
        press = '0; press2 = '0;
        nif.note_valid_i = 1'b0;  nif.note_mask_i = '0;
        nif2.note_valid_i = 1'b0; nif2.note_mask_i = '0;
        cyc(); cyc();
        check("rst_score", score, 0);
        check("rst_jv", jv, 0);
        check("rst_jc", jc, 0);
        rst_ni = 1'b1; rst2_ni = 1'b1;
        cyc();
        check("rst_ready", nif.note_ready_o, 1);
        check("rst_active", active, 0);

        // Perfect on the target frame
        issue(4'b0001);
        check("t1_ready_low", nif.note_ready_o, 0);
        check("t1_active", active, 4'b0001);
        frames(60);
        check("t1_pending", active, 4'b0001);
        press = 4'b0001; frame = 1'b1;
        cyc();
        check("t1_jv", jv, 4'b0001);
        check("t1_jc", jc, 8'h02);
        check("t1_score", score, 3);
        check("t1_combo", combo, 1);
        check("t1_ready", nif.note_ready_o, 1);

        // Two goods four frames early
        issue(4'b1010);
        frames(56);
        press = 4'b1010;
        cyc();
        check("t2_jv", jv, 4'b1010);
        check("t2_jc", jc, 8'h44);
        check("t2_score", score, 5);
        check("t2_combo", combo, 3);
        check("t2_max", max_combo, 3);

        // Miss five frames after the target frame
        issue(4'b0100);
        frames(65);
        check("t3_still_active", active, 4'b0100);
        check("t3_no_judge", jv, 0);
        frame = 1'b1;
        cyc();
        check("t3_jv", jv, 4'b0100);
        check("t3_jc", jc, 8'h00);
        check("t3_combo", combo, 0);
        check("t3_max", max_combo, 3);
        check("t3_active", active, 0);

        // Build combo to 7
        issue(4'b1111);
        frames(60);
        press = 4'b1111; frame = 1'b1;
        cyc();
        check("t4_jc", jc, 8'hAA);
        check("t4_score", score, 17);
        issue(4'b0111);
        frames(60);
        press = 4'b0111; frame = 1'b1;
        cyc();
        check("t4_jv", jv, 4'b0111);
        check("t4_combo", combo, 7);
        check("t4_max", max_combo, 7);

        // Stray on idle lane
        press = 4'b0001;
        cyc();
        check("t5_jc", jc, 8'h03);
        check("t5_combo", combo, 0);
        check("t5_max", max_combo, 7);
        check("t5_score", score, 26);

        // Early stray at err 10 keeps the note
        issue(4'b0001);
        frames(50);
        press = 4'b0001;
        cyc();
        check("t6_jv", jv, 4'b0001);
        check("t6_jc", jc, 8'h03);
        check("t6_active", active, 4'b0001);

        // Press at LATE cnt = GOOD_WIN with frame: good beats timeout
        frames(15);
        check("t7_active", active, 4'b0001);
        press = 4'b0001; frame = 1'b1;
        cyc();
        check("t7_jc", jc, 8'h01);
        check("t7_score", score, 27);
        check("t7_combo", combo, 1);

        // Clear drops notes without judging, and overrides a same-cycle press
        issue(4'b0011);
        frames(3);
        clear = 1'b1; press = 4'b0011;
        cyc();
        check("t8_jv", jv, 0);
        check("t8_active", active, 0);
        check("t8_score", score, 0);
        check("t8_max", max_combo, 0);
        check("t8_ready", nif.note_ready_o, 1);

        // SCOREW = 4 saturation
        issue2(4'b1111);
        frames(60);
        press2 = 4'b1111; frame = 1'b1;
        cyc();
        check("s1_score", score2, 12);
        issue2(4'b0011);
        frames(60);
        press2 = 4'b0011; frame = 1'b1;
        cyc();
        check("s1_sat", score2, 15);
        check("s1_combo", combo2, 6);

        // Asynchronous reset mid-approach
        issue2(4'b0001);
        frames(10);
        check("s2_active_pre", active2, 4'b0001);
        rst2_ni = 1'b0;
        #1;
        check("s2_active", active2, 0);
        check("s2_score", score2, 0);
        check("s2_combo", combo2, 0);
        check("s2_max", max_combo2, 0);
        check("s2_jv", jv2, 0);
        cyc();
        rst2_ni = 1'b1;
        cyc();
        check("s2_ready", nif2.note_ready_o, 1);
        frames(60);
        check("s2_no_judge", jv2, 0);
        check("s2_idle", active2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
